// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: folds CHUNK_W operand bits per cycle into a remainder below MODULUS.
// Define MOD_REDUCE_RANGE_CHECK_EN to flag operands at or above X_MAX on out_err.
module mod_reduce_seq #(
    parameter int MODULUS = 107,
    parameter int IN_W    = 9,
    parameter int CHUNK_W = 6,
    parameter int X_MAX   = 400,
    localparam int OUT_W  = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_r,
    output logic             out_err
);

    localparam int STEPS  = (IN_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = STEPS * CHUNK_W;
    localparam int ACC_W  = OUT_W + CHUNK_W;
    localparam int STEP_W = $clog2(STEPS + 1);
    localparam logic [ACC_W-1:0] MOD_EXT = ACC_W'(MODULUS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [OUT_W-1:0]   r_acc;
    logic [STEP_W-1:0]  r_step;
    logic [PAD_W-1:0]   r_x;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [OUT_W-1:0]   r_out_r;

    logic               w_accept;
    logic               w_last;
    logic               w_finish;
    logic               w_release;
    logic [OUT_W-1:0]   w_fold;

    // (acc*2^CHUNK_W + chunk) is below MODULUS*2^CHUNK_W, so subtracting
    // MODULUS*2^k for k = CHUNK_W-1 down to 0 leaves a value below MODULUS.
    function automatic logic [OUT_W-1:0] fold_step(input logic [OUT_W-1:0]   acc,
                                                   input logic [CHUNK_W-1:0] chunk);
        logic [ACC_W-1:0] v;
        v = {acc, chunk};
        for (int k = CHUNK_W - 1; k >= 0; k--) begin
            if (v >= (MOD_EXT << k)) v = v - (MOD_EXT << k);
        end
        return v[OUT_W-1:0];
    endfunction

    assign w_accept  = in_valid & r_in_ready;
    assign w_last    = (r_step == STEP_W'(STEPS - 1));
    assign w_finish  = (r_state == S_RUN) & w_last;
    assign w_release = (r_state == S_DONE) & out_ready;
    assign w_fold    = fold_step(r_acc, r_x[PAD_W-1 -: CHUNK_W]);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_step      <= '0;
            r_x         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_x        <= PAD_W'(in_x);
                        r_acc      <= '0;
                        r_step     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_fold;
                    r_x    <= r_x << CHUNK_W;
                    r_step <= r_step + STEP_W'(1);
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_out_r     <= w_fold;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Ready rises with the return to IDLE, so the next accept is one edge later.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_r     <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;

`ifdef MOD_REDUCE_RANGE_CHECK_EN
    logic r_err;
    logic r_out_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            if (w_accept) r_err <= (32'(in_x) >= 32'(X_MAX));
            if (w_finish) r_out_err <= r_err;
            else if (w_release) r_out_err <= 1'b0;
        end
    end

    assign out_err = r_out_err;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: doc/mod_reduce_seq.md
MOD_REDUCE_SEQ -- requirements
Module: mod_reduce_seq

Interface
REQ-001 SHALL have parameter MODULUS, default 107: modulus M, 2..2^16-1.
REQ-002 SHALL have parameter IN_W, default 9: operand width in bits.
REQ-003 SHALL have parameter CHUNK_W, default 6: bits folded per cycle, 1..8.
REQ-004 SHALL have parameter X_MAX, default 400: exclusive upper bound of the legal operand range.
REQ-005 SHALL derive localparams OUT_W = clog2(MODULUS) and STEPS = ceil(IN_W/CHUNK_W).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1: operand offered.
REQ-009 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-010 SHALL have port in_x, input, IN_W: operand.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port out_r, output, OUT_W: the value in_x mod MODULUS.
REQ-014 SHALL have port out_err, output, 1: operand is out of range (see Configuration).

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL treat the acceptance condition in_valid & in_ready as follows: latch in_x, zero-extended at the MSB to STEPS*CHUNK_W bits; clear the accumulator r and the step count; enter RUN.
REQ-018 SHALL process one chunk per RUN cycle, MSB chunk first, as r <= (r*2^CHUNK_W + chunk) mod MODULUS; r stays below MODULUS at all times.
REQ-019 SHALL update the accumulator without a divider: at most CHUNK_W conditional-subtract stages per step or an equivalent, all within one cycle.
REQ-020 SHALL enter DONE after exactly STEPS RUN cycles; out_valid is asserted STEPS cycles after the accept edge.
REQ-021 SHALL hold out_r and out_err stable in DONE until out_valid & out_ready; on that edge the FSM returns to IDLE.
REQ-022 SHALL NOT accept a new operand in the same cycle as the DONE-to-IDLE transition; the minimum issue interval is STEPS+2 cycles.
REQ-023 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-024 SHALL drive out_r = 0 and out_err = 0 whenever out_valid = 0.
REQ-025 SHALL produce the correct result for every IN_W-bit operand, including all-ones and operand = MODULUS.

Reset
REQ-026 SHALL, on rst_n low at any time and in any state, immediately force IDLE, r = 0, step count = 0, out_valid = 0, out_r = 0 and out_err = 0; the in-flight operand is discarded.
REQ-027 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with MOD_REDUCE_RANGE_CHECK_EN defined, latch out_err = (in_x >= X_MAX) at accept and present it in DONE alongside out_r; out_r is still computed.
REQ-029 SHALL, without MOD_REDUCE_RANGE_CHECK_EN, tie out_err to 0, omit the comparator, and leave all other timing unchanged.

Verification
REQ-030 SHALL cover this scenario: defaults, in_x = 399 accepted -> out_valid 2 cycles later, out_r = 78, out_err = 0.
REQ-031 SHALL cover this scenario: in_x in {0, 106, 107, 255, 511} -> out_r = {0, 106, 0, 41, 83}.
REQ-032 SHALL cover this scenario: out_ready held low for 10 cycles in DONE -> out_r stable and in_ready = 0 throughout; release -> IDLE, then in_ready = 1.
REQ-033 SHALL cover this scenario: rst_n pulsed low during RUN -> out_valid = 0 and in_ready = 1 after release; the next operand 200 gives out_r = 93.
REQ-034 SHALL cover this scenario: MOD_REDUCE_RANGE_CHECK_EN defined, in_x = 450 -> out_r = 22, out_err = 1; macro undefined -> out_err = 0.
REQ-035 SHALL cover this scenario: MODULUS = 251, IN_W = 16, CHUNK_W = 4, random operands -> all results match x mod 251 at a latency of 4 cycles.
